mult_err_monitor: RTL and testbench

Streaming error-characterisation stage that sits directly downstream of the 8x8 approximate multipliers. Each accepted sample pairs the approximate 16-bit product with the exact product of the same operands. Over a programmed window of N samples, the block accumulates:
- error count,
- maximum error distance,
- sum of error distances,
- signed error sum (bias).

Results are used for on-chip ranking of multiplier configurations without dumping every product.

---
 rtl/mult_err_monitor_pkg.sv | 27 ++
 rtl/mult_err_monitor_if.sv | 63 ++++++
 rtl/mult_err_monitor_err_calc.sv | 76 +++++++
 rtl/mult_err_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_mult_err_monitor.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_err_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_err_pkg
//  Description : Shared types and constants for the multiplier error monitor.
//                - state_e   : window FSM states
//                - PROD_W    : width of a 8x8 product (16)
//                - DIFF_W    : width of the signed product difference (17)
//                - DEF_CNT_W : default sample counter width
//                - DEF_ACC_W : default accumulator width
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_err_pkg;

    localparam int PROD_W    = 16;
    localparam int DIFF_W    = 17;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : mult_err_pkg
`default_nettype wire

// File: rtl/mult_err_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_err_monitor_if
//  Description : Sample stream and result bus of the multiplier error monitor.
//                master : producer / result consumer (drives start, samples)
//                slave  : the monitor (drives in_ready, status and results)
//                Signals: start, num_samples, in_valid, in_ready, approx,
//                         exact, busy, done, err_count, max_ed, sum_ed,
//                         sum_sed
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_err_monitor_if
    import mult_err_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) ();

    logic                start;
    logic [CNT_W-1:0]    num_samples;
    logic                in_valid;
    logic                in_ready;
    logic [PROD_W-1:0]   approx;
    logic [PROD_W-1:0]   exact;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    err_count;
    logic [PROD_W-1:0]   max_ed;
    logic [ACC_W-1:0]    sum_ed;
    logic [ACC_W-1:0]    sum_sed;

    modport master (
        output start,
        output num_samples,
        output in_valid,
        output approx,
        output exact,
        input  in_ready,
        input  busy,
        input  done,
        input  err_count,
        input  max_ed,
        input  sum_ed,
        input  sum_sed
    );

    modport slave (
        input  start,
        input  num_samples,
        input  in_valid,
        input  approx,
        input  exact,
        output in_ready,
        output busy,
        output done,
        output err_count,
        output max_ed,
        output sum_ed,
        output sum_sed
    );

endinterface : mult_err_monitor_if
`default_nettype wire

// File: rtl/mult_err_monitor_err_calc.sv
`default_nettype none
// ============================================================================
//  Module      : err_calc
//  Description : Stage 1 of the error monitor. Forms the signed difference
//                approx - exact, its magnitude and a non-zero flag, and
//                registers all three together with a valid bit.
//                Ports: clk, rst_n, in_valid, approx, exact (inputs)
//                       s1_valid, s1_diff, s1_ed, s1_nz (registered outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module err_calc
    import mult_err_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PROD_W-1:0]        approx,
    input  logic [PROD_W-1:0]        exact,
    output logic                     s1_valid,
    output logic signed [DIFF_W-1:0] s1_diff,
    output logic [PROD_W-1:0]        s1_ed,
    output logic                     s1_nz
);

    logic signed [DIFF_W-1:0] diff;
    logic [PROD_W-1:0]        ed;
    logic                     nz;

    logic                     s1_valid_d, s1_valid_q;
    logic signed [DIFF_W-1:0] s1_diff_d,  s1_diff_q;
    logic [PROD_W-1:0]        s1_ed_d,    s1_ed_q;
    logic                     s1_nz_d,    s1_nz_q;

    // Zero-extend both products so the 17-bit result is a true signed
    // difference. A negative difference never exceeds 65535 in magnitude,
    // so negating only the low 16 bits yields the exact absolute value.
    always_comb begin
        diff = $signed({1'b0, approx}) - $signed({1'b0, exact});
        ed   = diff[DIFF_W-1] ? (~diff[PROD_W-1:0] + 16'd1) : diff[PROD_W-1:0];
        nz   = (diff != '0);
    end

    // Data fields only load on a valid sample; the valid bit tracks every cycle.
    always_comb begin
        s1_valid_d = in_valid;
        s1_diff_d  = s1_diff_q;
        s1_ed_d    = s1_ed_q;
        s1_nz_d    = s1_nz_q;
        if (in_valid) begin
            s1_diff_d = diff;
            s1_ed_d   = ed;
            s1_nz_d   = nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_ed_q    <= '0;
            s1_nz_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_ed_q    <= s1_ed_d;
            s1_nz_q    <= s1_nz_d;
        end
    end

    assign s1_valid = s1_valid_q;
    assign s1_diff  = s1_diff_q;
    assign s1_ed    = s1_ed_q;
    assign s1_nz    = s1_nz_q;

endmodule : err_calc
`default_nettype wire

// File: rtl/mult_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : mult_err_monitor
//  Description : Windowed error characterisation of an approximate multiplier.
//                Over N accepted (approx, exact) pairs it accumulates the
//                error count, maximum error distance, saturating sum of error
//                distances and saturating signed error sum.
//                Ports: clk, rst_n (async, active-low)
//                       bus (mult_err_monitor_if.slave): start/num_samples,
//                       in_valid/in_ready/approx/exact, busy/done and results
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_err_monitor
    import mult_err_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_err_monitor_if.slave  bus
);

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic                     xfer;
    logic                     s1_valid;
    logic signed [DIFF_W-1:0] s1_diff;
    logic [PROD_W-1:0]        s1_ed;
    logic                     s1_nz;

    logic                     in_ready_d, in_ready_q;

    assign xfer = bus.in_valid & in_ready_q;

    err_calc u_err_calc (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (xfer),
        .approx   (bus.approx),
        .exact    (bus.exact),
        .s1_valid (s1_valid),
        .s1_diff  (s1_diff),
        .s1_ed    (s1_ed),
        .s1_nz    (s1_nz)
    );

    // ------------------------------------------------------------------
    // Window FSM and sample counter
    // ------------------------------------------------------------------
    state_e            state_d, state_q;
    logic [CNT_W-1:0]  n_d, n_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              clear;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    n_d   = bus.num_samples;
                    cnt_d = '0;
                    clear = 1'b1;
                    if (bus.num_samples != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last sample sits in stage 1 during this cycle and is
                // accumulated on the same edge that enters DONE, so the
                // results are final while done is high.
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered from the next state so in_ready falls together with the
        // final transfer and no extra sample slips in.
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulators
    // ------------------------------------------------------------------
    localparam logic [ACC_W-1:0] SED_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SED_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [CNT_W-1:0]  err_count_d, err_count_q;
    logic [PROD_W-1:0] max_ed_d,    max_ed_q;
    logic [ACC_W-1:0]  sum_ed_d,    sum_ed_q;
    logic [ACC_W-1:0]  sum_sed_d,   sum_sed_q;
    logic              sed_pos_sat_d, sed_pos_sat_q;
    logic              sed_neg_sat_d, sed_neg_sat_q;

    logic [ACC_W:0]    sum_ed_ext;
    logic [ACC_W:0]    sum_sed_ext;
    logic [ACC_W:0]    diff_ext;

    // One guard bit above the accumulator width exposes overflow: a carry
    // out for the unsigned sum, a disagreement of the top two bits for the
    // signed sum.
    always_comb begin
        diff_ext    = {{(ACC_W+1-DIFF_W){s1_diff[DIFF_W-1]}}, s1_diff};
        sum_ed_ext  = {1'b0, sum_ed_q} + {{(ACC_W+1-PROD_W){1'b0}}, s1_ed};
        sum_sed_ext = {sum_sed_q[ACC_W-1], sum_sed_q} + diff_ext;
    end

    always_comb begin
        err_count_d   = err_count_q;
        max_ed_d      = max_ed_q;
        sum_ed_d      = sum_ed_q;
        sum_sed_d     = sum_sed_q;
        sed_pos_sat_d = sed_pos_sat_q;
        sed_neg_sat_d = sed_neg_sat_q;
        if (clear) begin
            err_count_d   = '0;
            max_ed_d      = '0;
            sum_ed_d      = '0;
            sum_sed_d     = '0;
            sed_pos_sat_d = 1'b0;
            sed_neg_sat_d = 1'b0;
        end else if (s1_valid) begin
            err_count_d = err_count_q + CNT_W'(s1_nz);
            if (s1_ed > max_ed_q) begin
                max_ed_d = s1_ed;
            end
            // Once at all-ones the unsigned sum can only stay there, so the
            // clamp is naturally sticky.
            if (sum_ed_ext[ACC_W]) begin
                sum_ed_d = '1;
            end else begin
                sum_ed_d = sum_ed_ext[ACC_W-1:0];
            end
            // The signed sum holds its clamp value until the next start,
            // even if later samples would pull it back into range.
            if (sed_pos_sat_q || sed_neg_sat_q) begin
                sum_sed_d = sum_sed_q;
            end else if (sum_sed_ext[ACC_W] != sum_sed_ext[ACC_W-1]) begin
                if (sum_sed_ext[ACC_W]) begin
                    sum_sed_d     = SED_MIN;
                    sed_neg_sat_d = 1'b1;
                end else begin
                    sum_sed_d     = SED_MAX;
                    sed_pos_sat_d = 1'b1;
                end
            end else begin
                sum_sed_d = sum_sed_ext[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q   <= '0;
            max_ed_q      <= '0;
            sum_ed_q      <= '0;
            sum_sed_q     <= '0;
            sed_pos_sat_q <= 1'b0;
            sed_neg_sat_q <= 1'b0;
        end else begin
            err_count_q   <= err_count_d;
            max_ed_q      <= max_ed_d;
            sum_ed_q      <= sum_ed_d;
            sum_sed_q     <= sum_sed_d;
            sed_pos_sat_q <= sed_pos_sat_d;
            sed_neg_sat_q <= sed_neg_sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all straight from registers
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_count_q;
    assign bus.max_ed    = max_ed_q;
    assign bus.sum_ed    = sum_ed_q;
    assign bus.sum_sed   = sum_sed_q;

endmodule : mult_err_monitor
`default_nettype wire

// File: tb/tb_mult_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_err_monitor
//  Description : Self-checking bench for mult_err_monitor. Two instances run
//                the same stream: one with 32-bit accumulators and one with
//                18-bit accumulators so saturation is reachable. Window
//                records hold inputs and expected results; expected results
//                are queued when the stream is driven and compared on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [15:0] approx = '0;
    logic [15:0] exact = '0;

    always #5 clk = ~clk;

    mult_err_monitor_if #(.CNT_W(16), .ACC_W(32)) if32 ();
    mult_err_monitor_if #(.CNT_W(16), .ACC_W(18)) if18 ();

    assign if32.start       = start;
    assign if32.num_samples = num_samples;
    assign if32.in_valid    = in_valid;
    assign if32.approx      = approx;
    assign if32.exact       = exact;
    assign if18.start       = start;
    assign if18.num_samples = num_samples;
    assign if18.in_valid    = in_valid;
    assign if18.approx      = approx;
    assign if18.exact       = exact;

    mult_err_monitor #(.CNT_W(16), .ACC_W(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    mult_err_monitor #(.CNT_W(16), .ACC_W(18)) dut18 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if18.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Window table: length, first pair index, expected results for both widths
    typedef struct {
        int     n;
        int     first;
        int     cnt;
        int     mx;
        longint ed32;
        longint sed32;
        longint ed18;
        longint sed18;
    } win_t;

    typedef struct {
        int     cnt;
        int     mx;
        longint ed32;
        longint sed32;
        longint ed18;
        longint sed18;
        int     cyc;
    } exp_t;

    win_t tbl[8];
    int   pa[$];
    int   pe[$];
    exp_t exp_q[$];

    task automatic pp(input int a, input int e);
        pa.push_back(a);
        pe.push_back(e);
    endtask

    function automatic exp_t mk(input int w);
        exp_t x;
        x.cnt   = tbl[w].cnt;
        x.mx    = tbl[w].mx;
        x.ed32  = tbl[w].ed32;
        x.sed32 = tbl[w].sed32;
        x.ed18  = tbl[w].ed18;
        x.sed18 = tbl[w].sed18;
        x.cyc   = 0;
        return x;
    endfunction

    function automatic logic any_out_high();
        return |{if32.in_ready, if32.busy, if32.done, if32.err_count, if32.max_ed,
                 if32.sum_ed, if32.sum_sed,
                 if18.in_ready, if18.busy, if18.done, if18.err_count, if18.max_ed,
                 if18.sum_ed, if18.sum_sed};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: pop and compare on every done pulse, then check that done
    // is a single-cycle pulse and the results hold the following cycle.
    // ------------------------------------------------------------------
    exp_t held;
    bit   post = 1'b0;

    always @(negedge clk) begin : mon
        automatic exp_t x;
        if (rst_n) begin
            if (post) begin
                chk("done_pulse_width", if32.done | if18.done, 0);
                chk("hold_err_count", if32.err_count, held.cnt);
                chk("hold_sum_ed32", if32.sum_ed, held.ed32);
                chk("hold_sum_sed18", longint'($signed(if18.sum_sed)), held.sed18);
            end
            if (if32.done || if18.done) begin
                chk("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    chk("done_cycle", cyc, x.cyc);
                    chk("done_both", if32.done & if18.done, 1);
                    chk("err_count32", if32.err_count, x.cnt);
                    chk("max_ed32", if32.max_ed, x.mx);
                    chk("sum_ed32", if32.sum_ed, x.ed32);
                    chk("sum_sed32", longint'($signed(if32.sum_sed)), x.sed32);
                    chk("err_count18", if18.err_count, x.cnt);
                    chk("max_ed18", if18.max_ed, x.mx);
                    chk("sum_ed18", if18.sum_ed, x.ed18);
                    chk("sum_sed18", longint'($signed(if18.sum_sed)), x.sed18);
                    held <= x;
                    post <= 1'b1;
                end else begin
                    post <= 1'b0;
                end
            end else begin
                post <= 1'b0;
            end
        end else begin
            post <= 1'b0;
        end
    end

    task automatic wait_done(input string name);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    // Drive one table window; optional random in_valid gaps and an ignored
    // start pulse (with a different length) in the middle of RUN.
    task automatic run_window(input int w, input bit gaps, input bit mid_start);
        int   idx;
        int   guard;
        int   hi;
        bit   want;
        bit   busy_checked;
        bit   mid_done;
        exp_t x;
        x = mk(w);
        start       = 1'b1;
        num_samples = 16'(tbl[w].n);
        if (tbl[w].n == 0) begin
            x.cyc = cyc + 1;
            exp_q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
        if (tbl[w].n == 0) begin
            hi = 0;
            for (int k = 0; k < 3; k++) begin
                hi |= int'(if32.busy | if32.in_ready | if18.busy | if18.in_ready);
                @(negedge clk);
            end
            chk("n0_busy_ready_low", hi, 0);
        end else begin
            idx = 0;
            guard = 0;
            busy_checked = 1'b0;
            mid_done = 1'b0;
            while (idx < tbl[w].n && guard < 200) begin
                start    = 1'b0;
                in_valid = 1'b0;
                if (mid_start && idx == 2 && !mid_done) begin
                    start       = 1'b1;
                    num_samples = 16'd1;
                    mid_done    = 1'b1;
                end
                want = !gaps || ($urandom_range(0, 2) != 0);
                if (if32.in_ready && want) begin
                    if (!busy_checked) begin
                        chk("busy_in_run", if32.busy & if18.busy, 1);
                        busy_checked = 1'b1;
                    end
                    in_valid = 1'b1;
                    approx   = 16'(pa[tbl[w].first + idx]);
                    exact    = 16'(pe[tbl[w].first + idx]);
                    idx++;
                    if (idx == tbl[w].n) begin
                        x.cyc = cyc + 2;
                        exp_q.push_back(x);
                    end
                end
                @(negedge clk);
                guard++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            chk("window_samples_taken", idx, tbl[w].n);
            chk("ready_low_after_last", if32.in_ready | if18.in_ready, 0);
        end
        wait_done("done_seen");
    endtask

    initial begin
        // ---------------- table ----------------
        tbl[0] = '{4, pa.size(), 3, 65535, 65565, -65525, 65565, -65525};
        pp(100, 100); pp(120, 100); pp(90, 100); pp(0, 65535);
        tbl[1] = '{0, pa.size(), 0, 0, 0, 0, 0, 0};
        tbl[2] = '{8, pa.size(), 8, 65535, 524280, 524280, 262143, 131071};
        for (int i = 0; i < 8; i++) pp(65535, 0);
        tbl[3] = '{3, pa.size(), 3, 65535, 196605, -196605, 196605, -131072};
        pp(0, 65535); pp(0, 65535); pp(0, 65535);
        tbl[4] = '{4, pa.size(), 4, 65535, 262140, 131070, 262140, 131071};
        pp(65535, 0); pp(65535, 0); pp(65535, 0); pp(0, 65535);
        tbl[5] = '{5, pa.size(), 4, 1000, 1009, 999, 1009, 999};
        pp(7, 3); pp(3, 7); pp(5, 5); pp(1000, 0); pp(0, 1);
        tbl[6] = '{1, pa.size(), 1, 4, 4, 4, 4, 4};
        pp(7, 3);
        tbl[7] = '{3, pa.size(), 2, 10, 15, 5, 15, 5};
        pp(10, 0); pp(0, 5); pp(3, 3); pp(999, 0); pp(999, 0); pp(999, 0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", any_out_high(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table windows ----------------
        run_window(0, 1'b0, 1'b0);
        run_window(1, 1'b0, 1'b0);

        // N=3 with in_valid held high for 6 cycles: only 3 transfers
        begin
            exp_t x;
            x = mk(7);
            start       = 1'b1;
            num_samples = 16'd3;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("held_valid_ready_%0d", i), if32.in_ready & if18.in_ready, (i < 3) ? 1 : 0);
                in_valid = 1'b1;
                approx   = 16'(pa[tbl[7].first + i]);
                exact    = 16'(pe[tbl[7].first + i]);
                if (i == 2) begin
                    x.cyc = cyc + 2;
                    exp_q.push_back(x);
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            wait_done("held_valid_done_seen");
        end

        run_window(2, 1'b1, 1'b0);
        run_window(3, 1'b0, 1'b0);
        run_window(4, 1'b1, 1'b0);
        run_window(5, 1'b1, 1'b1);

        // Reset in the middle of a 5-sample window, then a fresh N=1 window
        start       = 1'b1;
        num_samples = 16'd5;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        approx   = 16'd42;
        exact    = 16'd40;
        @(negedge clk);
        approx   = 16'd43;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs_zero", any_out_high(), 0);
        @(negedge clk);
        chk("mid_reset_outputs_held", any_out_high(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_window(6, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected finish earlier", cyc);
        $fatal(1, "timeout");
    end

endmodule : tb_mult_err_monitor
`default_nettype wire
